// File: rtl/pg_bus_xcvr.sv
`default_nettype none
// ============================================================================
// Module   : pg_bus_xcvr
// Purpose  : Half-duplex serial transceiver controller behind a pass-gate cell
//            on a shared idle-high line.
// Revision : 1.0
// ============================================================================
module pg_bus_xcvr #(
  parameter int WIDTH = 8,
  parameter int QUIET = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TX_VALID,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic             TX_READY,
  output logic             RX_VALID,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_ERR,
  output logic             COLL,
  input  logic             BUS_IN,
  output logic             BUS_OUT,
  output logic             GATE_N,
  output logic             GATE_P
);

  localparam int c_cw = $clog2(WIDTH + 1);
  localparam int c_qw = $clog2(QUIET + 1);
  localparam logic [c_cw-1:0] c_last  = c_cw'(WIDTH - 1);
  localparam logic [c_qw-1:0] c_quiet = c_qw'(QUIET);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_START = 3'd1,
    S_TX_DATA  = 3'd2,
    S_TX_STOP  = 3'd3,
    S_RX_DATA  = 3'd4,
    S_RX_STOP  = 3'd5
  } state_t;

  state_t           r_state;
  logic [c_qw-1:0]  r_quiet;
  logic [c_cw-1:0]  r_bitcnt;
  logic [WIDTH-1:0] r_txsh;
  logic [WIDTH-1:0] r_rxsh;
  logic             r_tx_ready;
  logic             r_rx_valid;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_err;
  logic             r_coll;
  logic             r_bus_out;
  logic             r_gate_n;
  logic             r_gate_p;

  logic [c_qw-1:0]  w_quiet_nxt;
  logic [WIDTH-1:0] w_rx_shift;

  assign w_quiet_nxt = (r_quiet == c_quiet) ? r_quiet : r_quiet + c_qw'(1);
  // LSB-first reception: new bit enters at the top and walks down.
  assign w_rx_shift  = (r_rxsh >> 1) | (WIDTH'(BUS_IN) << (WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_quiet    <= '0;
      r_bitcnt   <= '0;
      r_txsh     <= '0;
      r_rxsh     <= '0;
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_err   <= 1'b0;
      r_coll     <= 1'b0;
      r_bus_out  <= 1'b1;
      r_gate_n   <= 1'b0;
      r_gate_p   <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_coll     <= 1'b0;
      r_tx_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!BUS_IN) begin
            // A start bit wins over any pending transmit request.
            r_state  <= S_RX_DATA;
            r_bitcnt <= '0;
            r_quiet  <= '0;
          end else if (TX_VALID && r_tx_ready) begin
            r_state   <= S_TX_START;
            r_txsh    <= TX_DATA;
            r_quiet   <= '0;
            r_bus_out <= 1'b0;
            r_gate_n  <= 1'b1;
            r_gate_p  <= 1'b0;
          end else begin
            r_quiet    <= w_quiet_nxt;
            r_tx_ready <= (w_quiet_nxt == c_quiet);
          end
        end
        S_TX_START: begin
          r_state   <= S_TX_DATA;
          r_bitcnt  <= '0;
          r_bus_out <= r_txsh[0];
          r_txsh    <= r_txsh >> 1;
        end
        S_TX_DATA: begin
          if (BUS_IN != r_bus_out) begin
            r_state   <= S_IDLE;
            r_coll    <= 1'b1;
            r_bus_out <= 1'b1;
            r_gate_n  <= 1'b0;
            r_gate_p  <= 1'b1;
          end else if (r_bitcnt == c_last) begin
            r_state   <= S_TX_STOP;
            r_bus_out <= 1'b1;
          end else begin
            r_bitcnt  <= r_bitcnt + c_cw'(1);
            r_bus_out <= r_txsh[0];
            r_txsh    <= r_txsh >> 1;
          end
        end
        S_TX_STOP: begin
          r_state   <= S_IDLE;
          r_coll    <= (BUS_IN != r_bus_out);
          r_bus_out <= 1'b1;
          r_gate_n  <= 1'b0;
          r_gate_p  <= 1'b1;
        end
        S_RX_DATA: begin
          r_rxsh <= w_rx_shift;
          if (r_bitcnt == c_last) begin
            r_state <= S_RX_STOP;
          end else begin
            r_bitcnt <= r_bitcnt + c_cw'(1);
          end
        end
        S_RX_STOP: begin
          r_state <= S_IDLE;
          if (BUS_IN) begin
            r_rx_data  <= r_rxsh;
            r_rx_valid <= 1'b1;
          end else begin
            r_rx_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign TX_READY = r_tx_ready;
  assign RX_VALID = r_rx_valid;
  assign RX_DATA  = r_rx_data;
  assign RX_ERR   = r_rx_err;
  assign COLL     = r_coll;
  assign BUS_OUT  = r_bus_out;
  assign GATE_N   = r_gate_n;
  assign GATE_P   = r_gate_p;

endmodule
`default_nettype wire

// File: tb/tb_pg_bus_xcvr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pg_bus_xcvr
// Purpose  : Self-checking bench for pg_bus_xcvr with a frame-level line model.
// Revision : 1.0
// ============================================================================
module tb_pg_bus_xcvr;

  localparam int W = 8;
  localparam int Q = 2;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         ext_drv  = 1'b1;
  logic         run_chk  = 1'b0;
  logic         tx_ready, rx_valid, rx_err, coll, bus_in, bus_out, gate_n, gate_p;
  logic [W-1:0] rx_data;

  int           n_chk      = 0;
  int           n_fail     = 0;
  int           cyc        = 0;
  int           idle_since = 0;
  logic [W-1:0] last_good  = '0;

  always #5 clk = ~clk;

  // Open-drain style shared line: anyone pulling low wins, pull-up otherwise.
  assign bus_in = ext_drv & ((gate_n & ~gate_p) ? bus_out : 1'b1);

  pg_bus_xcvr #(.WIDTH(W), .QUIET(Q)) u_dut (
    .CLK      (clk),
    .RST      (rst),
    .TX_VALID (tx_valid),
    .TX_DATA  (tx_data),
    .TX_READY (tx_ready),
    .RX_VALID (rx_valid),
    .RX_DATA  (rx_data),
    .RX_ERR   (rx_err),
    .COLL     (coll),
    .BUS_IN   (bus_in),
    .BUS_OUT  (bus_out),
    .GATE_N   (gate_n),
    .GATE_P   (gate_p)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (run_chk) check("gate_cmp", gate_p, !gate_n);
  end

  task automatic wait_gap(input int gap);
    for (int g = 0; g < gap; g++) begin
      check("rdy_gap", tx_ready, cyc >= idle_since + Q);
      check("gate_idle", gate_n, 1'b0);
      tick();
    end
  endtask

  // Sends w; coll_at pulls the line low during that frame bit (W = stop bit),
  // rst_at asserts reset during that frame bit. Negative disables either.
  task automatic tx_word(input logic [W-1:0] w, input int coll_at, input int rst_at,
                         input int gap);
    logic b;
    logic hit;
    logic did_rst;
    hit     = 1'b0;
    did_rst = 1'b0;
    wait_gap(gap);
    tx_valid = 1'b1;
    tx_data  = w;
    for (int k = 0; k <= Q && cyc < idle_since + Q; k++) begin
      check("rdy_wait", tx_ready, 1'b0);
      tick();
      check("no_early_acc", gate_n, 1'b0);
    end
    check("rdy_acc", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
    tx_data  = W'($urandom);
    check("start_gate", gate_n, 1'b1);
    check("start_bit", bus_out, 1'b0);
    check("rdy_busy", tx_ready, 1'b0);
    for (int i = 0; i <= W; i++) begin
      tick();
      ext_drv = 1'b1;
      b = (i < W) ? w[i] : 1'b1;
      check("tx_bit", bus_out, b);
      check("tx_gate", gate_n, 1'b1);
      check("tx_coll", coll, 1'b0);
      if (i == rst_at) begin
        rst     = 1'b1;
        did_rst = 1'b1;
        break;
      end
      if (i == coll_at) begin
        ext_drv = 1'b0;
        hit     = b;
        if (b) break;
      end
    end
    tick();
    ext_drv = 1'b1;
    if (did_rst) begin
      rst = 1'b0;
      check("rst_gate_n", gate_n, 1'b0);
      check("rst_gate_p", gate_p, 1'b1);
      check("rst_bus", bus_out, 1'b1);
      check("rst_rdy", tx_ready, 1'b0);
      check("rst_coll", coll, 1'b0);
      check("rst_rxv", rx_valid, 1'b0);
      check("rst_rxe", rx_err, 1'b0);
      check("rst_rxd", rx_data, '0);
      last_good = '0;
    end else begin
      check("end_coll", coll, hit);
      check("end_gate", gate_n, 1'b0);
      check("end_bus", bus_out, 1'b1);
      check("end_rxv", rx_valid, 1'b0);
      check("end_rxe", rx_err, 1'b0);
    end
    idle_since = cyc;
    tick();
    check("coll_pulse", coll, 1'b0);
    check("rx_quiet", rx_valid, 1'b0);
  endtask

  // Drives a frame from the far end; contend raises TX_VALID with the start bit.
  task automatic rx_word(input logic [W-1:0] w, input logic stopb, input logic contend,
                         input int gap);
    wait_gap(gap);
    check("rdy_pre_rx", tx_ready, cyc >= idle_since + Q);
    ext_drv = 1'b0;
    if (contend) begin
      tx_valid = 1'b1;
      tx_data  = W'($urandom);
    end
    for (int i = 0; i < W; i++) begin
      tick();
      check("rx_gate", gate_n, 1'b0);
      check("rx_rdy", tx_ready, 1'b0);
      check("rx_hold", rx_data, last_good);
      check("rx_novalid", rx_valid, 1'b0);
      ext_drv = w[i];
    end
    tick();
    check("rx_gate_stop", gate_n, 1'b0);
    ext_drv = stopb;
    tick();
    ext_drv = 1'b1;
    check("rx_valid", rx_valid, stopb);
    check("rx_err", rx_err, !stopb);
    if (stopb) last_good = w;
    check("rx_data", rx_data, last_good);
    check("rx_gate_end", gate_n, 1'b0);
    idle_since = cyc;
    tick();
    check("rx_pulse", rx_valid, 1'b0);
    check("err_pulse", rx_err, 1'b0);
    check("rx_rdy_post", tx_ready, cyc >= idle_since + Q);
  endtask

  initial begin
    repeat (3) tick();
    rst        = 1'b0;
    run_chk    = 1'b1;
    idle_since = cyc;
    check("rst_rdy", tx_ready, 1'b0);
    check("rst_gate_n", gate_n, 1'b0);
    check("rst_gate_p", gate_p, 1'b1);
    check("rst_bus", bus_out, 1'b1);
    check("rst_rxv", rx_valid, 1'b0);
    check("rst_rxd", rx_data, '0);
    check("rst_rxe", rx_err, 1'b0);
    check("rst_coll", coll, 1'b0);
    wait_gap(3);

    tx_word(8'hA5, -1, -1, 0);
    rx_word(8'h3C, 1'b1, 1'b0, 1);
    rx_word(8'hC3, 1'b0, 1'b0, 0);
    rx_word(8'h81, 1'b1, 1'b1, 2);
    tx_word(8'h5A, -1, -1, 0);
    tx_word(8'hFF, 3, -1, 0);
    tx_word(8'hFF, -1, 4, 1);

    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: tx_word(W'($urandom), -1, -1, gap);
        1: tx_word(W'($urandom), int'($urandom_range(0, W)), -1, gap);
        2: rx_word(W'($urandom), 1'($urandom_range(0, 1)), 1'b0, gap);
        default: begin
          rx_word(W'($urandom), 1'b1, 1'b1, gap);
          tx_word(W'($urandom), -1, -1, 0);
        end
      endcase
    end

    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pg_bus_xcvr.md
# pg_bus_xcvr

Half-duplex serial transceiver controller for a single shared line driven through a pass-gate cell (data input, complementary N/P enables, bidirectional output). It owns the gate enables, frames outgoing words, samples incoming words when the gate is off, and enforces a quiet-line turnaround before driving. It is the sequential controller that sits behind the pass gate on a shared open line with an idle-high pull-up.

## Interface
- WIDTH, 8, data bits per frame (≥1)
- QUIET, 2, consecutive idle-high cycles required before transmit is allowed (≥1)

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- TX_VALID  in  1  transmit request
- TX_DATA  in  WIDTH  word to send, captured on accept
- TX_READY  out  1  controller can accept a word this cycle
- RX_VALID  out  1  one-cycle pulse: RX_DATA holds a new good word
- RX_DATA  out  WIDTH  last good received word
- RX_ERR  out  1  one-cycle pulse: framing error (stop bit 0)
- COLL  out  1  one-cycle pulse: transmit aborted on collision
- BUS_IN  in  1  sampled line value
- BUS_OUT  out  1  data to pass-gate data input
- GATE_N  out  1  N enable; gate conducts when GATE_N=1 and GATE_P=0
- GATE_P  out  1  P enable; always the complement of GATE_N

## Operation
- Frame: start bit 0, WIDTH data bits LSB first, stop bit 1; one bit per cycle. Line idles high.
- States: IDLE, TX_START, TX_DATA, TX_STOP, RX_DATA, RX_STOP.
- Quiet counter: in IDLE, counts consecutive BUS_IN=1 cycles, saturating at QUIET. It clears on BUS_IN=0 and on every entry to IDLE.
- TX_READY is 1 only in IDLE with quiet counter = QUIET and BUS_IN=1. Accept = TX_VALID & TX_READY, leading to TX_START.
- IDLE with BUS_IN=0 leads to RX_DATA. A start bit outranks a pending TX_VALID in the same cycle: no accept.
- TX_START: gate on, BUS_OUT=0. TX_DATA: WIDTH cycles, BUS_OUT = bit i. TX_STOP: BUS_OUT=1. Then IDLE with gate off.
- Collision: in TX_DATA or TX_STOP, if BUS_IN ≠ BUS_OUT, the controller:
  - asserts COLL the next cycle,
  - turns the gate off the next cycle,
  - goes to IDLE.
- No collision check in TX_START.
- RX_DATA: samples BUS_IN for WIDTH cycles into a shift register. RX_STOP then samples the stop bit:
  - 1: RX_DATA updates and RX_VALID pulses.
  - 0: RX_ERR pulses and RX_DATA keeps its old value.
  - Either way, the next state is IDLE.
- BUS_IN is ignored for reception while transmitting.
- Bit counter width is clog2(WIDTH+1). It wraps only by reload on state entry.

## Timing
- All outputs are registered.
- Reset values: GATE_N=0, GATE_P=1, BUS_OUT=1, TX_READY=0, RX_VALID=0, RX_DATA=0, RX_ERR=0, COLL=0. State = IDLE, quiet counter = 0.
- RST has priority over all events. Asserting RST mid-frame turns the gate off on the next edge, drops any partial word, and pulses nothing.
- TX, with accept at cycle 0:
  - cycle 1: gate on, BUS_OUT=0.
  - cycles 2..WIDTH+1: data bits.
  - cycle WIDTH+2: stop bit.
  - cycle WIDTH+3: gate off, BUS_OUT=1.
  - Earliest next accept: cycle WIDTH+3+QUIET.
- RX, with start seen at cycle 0:
  - cycles 1..WIDTH: data bits sampled.
  - cycle WIDTH+1: stop bit sampled.
  - cycle WIDTH+2: RX_VALID or RX_ERR high for exactly one cycle.
- After reset, TX_READY first rises QUIET cycles after the first IDLE cycle with BUS_IN=1.
- GATE_N and GATE_P never hold the same value in any cycle.

## Test plan
- Reset, BUS_IN=1: TX_READY=0 for cycles 0–1, then 1 at cycle 2 (QUIET=2). GATE_N=0 and GATE_P=1 throughout.
- TX_DATA=8'hA5 accepted at cycle 0 with BUS_IN looped back from BUS_OUT:
  - BUS_OUT sequence 0,1,0,1,0,0,1,0,1,1 over cycles 1–10.
  - Gate on over cycles 1–10, off at cycle 11.
  - TX_READY back at cycle 13.
- BUS_IN frame 0,(0x3C LSB first),1: RX_VALID=1 with RX_DATA=8'h3C at cycle 10. A second frame with stop bit 0 gives RX_ERR=1 and RX_DATA stays 8'h3C.
- TX_VALID=1 in the same cycle BUS_IN falls to 0: no accept; the word 8'h81 is received; TX is accepted QUIET cycles after the stop bit.
- TX of 8'hFF with BUS_IN forced to 0 at data bit 3: COLL pulses and the gate goes off the next cycle, then IDLE; no RX_VALID.
- RST asserted at TX data bit 4: next cycle GATE_N=0, BUS_OUT=1, TX_READY=0, no COLL or RX pulses.
